// File: rtl/left_shift_sequencer.sv
// left_shift_sequencer
//   Multi-cycle logical left shifter. A request's total shift amount is applied
//   to an internal register in steps of at most 7 positions per cycle. Each step
//   matches the range of one 3-bit-shamt shift stage. The LSB is zero-filled, and
//   bits shifted past the MSB are discarded.
//
// Ports
//   i_clk     clock, rising edge
//   i_arst_n  asynchronous active-low reset
//   i_valid   request valid
//   o_ready   request accepted on i_valid & o_ready
//   i_data    operand
//   i_shamt   total left-shift amount, 0..WIDTH-1
//   i_flush   synchronous abort, overrides accept and shift
//   o_valid   result valid (DONE state)
//   i_ready   downstream accepts result on o_valid & i_ready
//   o_data    registered result, updated only on entry to DONE
//   o_busy    high while shifting
module left_shift_sequencer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               i_clk,
    input  logic               i_arst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_busy
);

    // Fixed by the downstream 3-bit-shamt stage.
    localparam int unsigned        STEP_MAX   = 7;
    localparam logic [SHAMT_W-1:0] STEP_MAX_W = SHAMT_W'(STEP_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [SHAMT_W-1:0] step;
    logic [WIDTH-1:0]   shifted;
    logic               accept;

    // i_ready -> o_ready is combinational on purpose, for back-to-back throughput.
    assign o_ready = (state_q == StIdle) | ((state_q == StDone) & i_ready);
    assign accept  = i_valid & o_ready & ~i_flush;

    assign step    = (rem_q > STEP_MAX_W) ? STEP_MAX_W : rem_q;
    assign shifted = data_q << step;

    assign o_valid = (state_q == StDone);
    assign o_busy  = (state_q == StShift);
    assign o_data  = out_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        out_d   = out_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    data_d  = i_data;
                    rem_d   = i_shamt;
                    state_d = (i_shamt == '0) ? StDone : StShift;
                    if (i_shamt == '0) out_d = i_data;
                end
            end
            StShift: begin
                data_d = shifted;
                rem_d  = rem_q - step;
                // Last step: remaining fits in one stage.
                if (rem_q <= STEP_MAX_W) begin
                    state_d = StDone;
                    out_d   = shifted;
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                    // A request accepted on the same edge replaces the data.
                    if (accept) begin
                        data_d  = i_data;
                        rem_d   = i_shamt;
                        state_d = (i_shamt == '0) ? StDone : StShift;
                        if (i_shamt == '0) out_d = i_data;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush aborts everything in flight; the last delivered result stays.
        if (i_flush) begin
            state_d = StIdle;
            rem_d   = '0;
            data_d  = data_q;
            out_d   = out_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            rem_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_left_shift_sequencer.sv
module tb_left_shift_sequencer;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;

    logic               clk;
    logic               arst_n;
    logic               in_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               flush;
    logic               out_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               busy;

    int vectors;
    int miscompares;

    left_shift_sequencer #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .i_clk    (clk),
        .i_arst_n (arst_n),
        .i_valid  (in_valid),
        .o_ready  (out_ready),
        .i_data   (in_data),
        .i_shamt  (in_shamt),
        .i_flush  (flush),
        .o_valid  (out_valid),
        .i_ready  (in_ready),
        .o_data   (out_data),
        .o_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular shift, latency = ceil(n/7) shifting cycles.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input int n);
        logic [2*WIDTH-1:0] wide;
        wide = {{WIDTH{1'b0}}, d} << n;
        return wide[WIDTH-1:0];
    endfunction

    function automatic int ref_cycles(input int n);
        return (n + 6) / 7;
    endfunction

    // Issue one request from IDLE, wait for result, stall, then hand it off.
    task automatic run(input logic [WIDTH-1:0] d, input int n, input int stall, input string tag);
        int bcnt;
        int guard;
        logic [WIDTH-1:0] exp;
        exp = ref_shift(d, n);
        chk({tag, ".ready_idle"}, {31'd0, out_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = SHAMT_W'(n);
        in_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
        in_shamt = SHAMT_W'($urandom);
        bcnt  = 0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            if (busy) bcnt++;
            guard++;
            tick();
        end
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".busy_cycles"}, bcnt, ref_cycles(n));
        chk({tag, ".data"}, out_data, exp);
        for (int k = 0; k < stall; k++) begin
            tick();
            chk({tag, ".stall_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, ".stall_data"}, out_data, exp);
            chk({tag, ".stall_ready"}, {31'd0, out_ready}, 32'd0);
        end
        in_ready = 1'b1;
        #1;
        chk({tag, ".ready_comb"}, {31'd0, out_ready}, 32'd1);
        tick();
        in_ready = 1'b0;
        chk({tag, ".after_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".after_data"}, out_data, exp);
    endtask

    initial begin
        int guard;
        logic [WIDTH-1:0] last;

        vectors     = 0;
        miscompares = 0;
        arst_n   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_shamt = '0;
        flush    = 1'b0;
        in_ready = 1'b0;
        #1;
        chk("reset.valid", {31'd0, out_valid}, 32'd0);
        chk("reset.data", out_data, 32'd0);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.ready", {31'd0, out_ready}, 32'd1);
        #11 arst_n = 1'b1;
        tick();

        // Directed cases.
        run(32'h0000_0001, 0, 0, "n0");
        run(32'h0000_0001, 31, 1, "n31");
        run(32'hFFFF_FFFF, 8, 0, "n8");
        run(32'h0000_0001, 7, 0, "n7");

        // Long stall followed by a same-edge handoff and new request.
        in_valid = 1'b1; in_data = 32'h1; in_shamt = 5'd7; in_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("b2b.first_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b.first_data", out_data, 32'h0000_0080);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("b2b.hold_valid", {31'd0, out_valid}, 32'd1);
            chk("b2b.hold_data", out_data, 32'h0000_0080);
            chk("b2b.hold_ready", {31'd0, out_ready}, 32'd0);
        end
        in_ready = 1'b1; in_valid = 1'b1; in_data = 32'h3; in_shamt = 5'd1;
        tick();
        in_ready = 1'b0; in_valid = 1'b0;
        chk("b2b.no_idle_busy", {31'd0, busy}, 32'd1);
        chk("b2b.mid_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("b2b.second_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b.second_data", out_data, 32'h0000_0006);
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;

        // Flush on the second shifting cycle.
        in_valid = 1'b1; in_data = $urandom; in_shamt = 5'd20;
        tick();
        in_valid = 1'b0;
        chk("flush.busy1", {31'd0, busy}, 32'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.busy", {31'd0, busy}, 32'd0);
        chk("flush.ready", {31'd0, out_ready}, 32'd1);
        chk("flush.data_kept", out_data, 32'h0000_0006);
        guard = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) guard++;
            tick();
        end
        chk("flush.never_valid", guard, 0);

        // Flush blocks capture of a request presented in IDLE.
        in_valid = 1'b1; in_data = 32'h55; in_shamt = 5'd0; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle.valid", {31'd0, out_valid}, 32'd0);
        chk("flush_idle.busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-shift.
        in_valid = 1'b1; in_data = $urandom | 32'h1; in_shamt = 5'd30;
        tick();
        in_valid = 1'b0;
        tick();
        #2 arst_n = 1'b0;
        #1;
        chk("areset.valid", {31'd0, out_valid}, 32'd0);
        chk("areset.data", out_data, 32'd0);
        chk("areset.busy", {31'd0, busy}, 32'd0);
        #1 arst_n = 1'b1;
        tick();
        run(32'h0000_0005, 3, 0, "post_reset");

        // Random sweep over every shift amount.
        for (int n = 0; n < 32; n++) begin
            run($urandom, n, $urandom_range(0, 3), "sweep");
        end
        for (int r = 0; r < 20; r++) begin
            run($urandom, $urandom_range(0, 31), $urandom_range(0, 2), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
